// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided square wave plus a wrap tick.
// A new divisor/high-time pair is staged via valid/ready and swapped in only at a period boundary.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned DEFAULT_DIV = 512,
  parameter int unsigned DEFAULT_HI  = 256
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_hi,
  output logic             cfg_applied,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HI_RST  = WIDTH'(DEFAULT_HI);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] active_hi;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] pend_hi;
  logic             pend_valid;

  logic [WIDTH-1:0] san_div;
  logic [WIDTH-1:0] san_hi;
  logic             accept;
  logic             wrap;
  logic             apply;

  // Clamp the offered pair so the period is at least 2 and high time lies in 1..div-1.
  always_comb begin
    san_div = (cfg_div < TWO) ? TWO : cfg_div;
    san_hi  = cfg_hi;
    if (cfg_hi == '0)
      san_hi = ONE;
    else if (cfg_hi >= san_div)
      san_hi = san_div - ONE;
  end

  assign cfg_ready = !pend_valid;
  assign accept    = cfg_valid & !pend_valid;
  assign wrap      = en & (counter == active_div - ONE);
  assign apply     = pend_valid & (wrap | !en);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!en || wrap)
        counter <= '0;
      else
        counter <= counter + ONE;
      clk_out <= en & (counter < active_hi);
      tick    <= wrap;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      active_div  <= DIV_RST;
      active_hi   <= HI_RST;
      pend_div    <= DIV_RST;
      pend_hi     <= HI_RST;
      pend_valid  <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      cfg_applied <= apply;
      if (apply) begin
        active_div <= pend_div;
        active_hi  <= pend_hi;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_div   <= san_div;
        pend_hi    <= san_hi;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable clock divider, the parametrised successor of the fixed-divisor divider used for LED panel scan and shift timing. It generates a divided square wave, `clk_out`, with a programmable period and high time. It also produces a one-cycle `tick` strobe at each period wrap, usable as a clock enable. New divisor/high-time pairs are loaded through a valid/ready handshake and take effect only at a period boundary, so `clk_out` never glitches.

Parameters:
WIDTH, 20, width of counter, divisor and high-time fields
DEFAULT_DIV, 512, period in clk_in cycles after reset (must satisfy 2 <= DEFAULT_DIV < 2^WIDTH)
DEFAULT_HI, 256, high time in clk_in cycles after reset (1 <= DEFAULT_HI < DEFAULT_DIV)

Ports:
clk_in  input  1  sole clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low = halted and counter cleared
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  block can accept a configuration (no update pending)
cfg_div  input  WIDTH  requested period in clk_in cycles
cfg_hi  input  WIDTH  requested high time in clk_in cycles
cfg_applied  output  1  one-cycle pulse when a pending configuration becomes active
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse, registered, on the last cycle of each period

Behaviour:
- Reset (async assert, sync release): counter=0, active_div=DEFAULT_DIV, active_hi=DEFAULT_HI, pend_valid=0, clk_out=0, tick=0, cfg_applied=0, cfg_ready=1.
- cfg_ready = !pend_valid (combinational from the register).
- Handshake: a transfer occurs on a cycle with cfg_valid & cfg_ready. Captured fields are sanitised before storing in pend_div/pend_hi:
  - div < 2 -> div = 2
  - hi = 0 -> hi = 1
  - hi >= div (after div clamp) -> hi = div-1
  - pend_valid is set the following cycle.
- Wrap condition: wrap = en & (counter == active_div-1).
- Counter:
  - en=0 -> counter <= 0.
  - else wrap -> counter <= 0.
  - else counter <= counter+1.
  - The counter never exceeds active_div-1.
- Apply:
  - If pend_valid & (wrap | !en): active_div <= pend_div, active_hi <= pend_hi, pend_valid <= 0, cfg_applied <= 1 for one cycle.
  - A new period after apply starts at counter 0 with the new values.
- Simultaneous handshake and apply on the same cycle cannot occur, because cfg_ready=0 while pend_valid=1.
- Same-cycle accept then wrap: the new config waits for the next wrap. There is no same-cycle bypass.
- clk_out <= en & (counter < active_hi). This is registered, so clk_out lags the counter by 1 cycle. With en=1 the output is high for active_hi cycles and low for active_div-active_hi cycles of every period.
- tick <= wrap. Period between ticks = active_div cycles.
- en falling:
  - clk_out goes 0 and tick goes 0 on the next edge.
  - The counter clears.
  - The pending config applies immediately.
- en rising: the counter starts from 0; the first clk_out high appears 1 cycle later.
- Reset mid-operation discards any pending config and restores the defaults.
- Arithmetic is unsigned WIDTH bits. The compare active_div-1 cannot underflow, because active_div >= 2.

Test Plan:
1. Reset, en=1, defaults 512/256 -> clk_out high 256 / low 256 cycles repeating; tick every 512 cycles; first tick when counter=511.
2. Mid-period, offer cfg_div=10, cfg_hi=3 -> cfg_ready drops the cycle after accept. Old period completes unchanged. cfg_applied pulses on the wrap cycle's next edge. Then clk_out is 3 high / 7 low and tick every 10 cycles.
3. cfg_div=1, cfg_hi=0 -> sanitised to 2/1; clk_out toggles every cycle; tick every 2 cycles. cfg_div=8, cfg_hi=20 -> 8/7.
4. Config accepted while en=0 -> applied the next cycle (cfg_applied pulse) with no wrap needed. Raising en yields the new waveform from counter 0.
5. cfg_valid held high while pend_valid=1 -> no second capture until after cfg_applied. Back-to-back configs (4/2 then 6/3) each apply at successive wraps.
6. Assert rst asynchronously mid-period with a config pending -> all outputs 0 immediately, cfg_ready=1. After release with en=1, the 512/256 waveform resumes; the discarded config never applies.
